// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the router 1x3 input port.
// Builds header/payload/parity packets and tracks router parity errors.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int ERR_WIN    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    output logic       start_ready,
    output logic       req_reject,
    input  logic [7:0] pld_data,
    input  logic       pld_valid,
    output logic       pld_ready,
    input  logic       busy,
    input  logic       err,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_done,
    output logic       underrun,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        ERRWIN,
        GAP
    } state_t;

    localparam logic [3:0] WIN_LAST = 4'(ERR_WIN - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [5:0] len_q;
    logic [1:0] addr_q;
    logic [5:0] cnt_q;
    logic [7:0] par_q;
    logic [3:0] tmr_q;
    logic       err_seen;
    logic       req_ok;
    logic [7:0] header;

    assign req_ok      = (dest_addr != 2'd3) && (pay_len != 6'd0);
    assign header      = {len_q, addr_q};
    assign start_ready = (state == IDLE);
    assign pkt_valid   = (state == HEADER) || (state == PAYLOAD);
    assign pld_ready   = (state == PAYLOAD) && pld_valid && !busy;

    // Byte presented to the router; a starved payload slot sends zero
    always_comb begin
        pkt_data = 8'h00;
        case (state)
            HEADER:  pkt_data = header;
            PAYLOAD: pkt_data = pld_valid ? pld_data : 8'h00;
            PARITY:  pkt_data = par_q;
            default: pkt_data = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; byte states only advance when busy is low
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && req_ok) state_nx = HEADER;
            HEADER:  if (!busy) state_nx = PAYLOAD;
            PAYLOAD: if (!busy && cnt_q == 6'd1) state_nx = PARITY;
            PARITY:  if (!busy) state_nx = ERRWIN;
            ERRWIN:  if (tmr_q == WIN_LAST) state_nx = GAP;
            GAP:     if (tmr_q == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: request latch, byte counter, parity, timers, status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            par_q      <= '0;
            tmr_q      <= '0;
            err_seen   <= 1'b0;
            req_reject <= 1'b0;
            pkt_done   <= 1'b0;
            underrun   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            req_reject <= (state == IDLE) && start && !req_ok;
            pkt_done   <= (state == PARITY) && !busy;
            case (state)
                IDLE: begin
                    if (start && req_ok) begin
                        len_q    <= pay_len;
                        addr_q   <= dest_addr;
                        underrun <= 1'b0;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        par_q <= header;
                        cnt_q <= len_q;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        cnt_q <= cnt_q - 6'd1;
                        par_q <= par_q ^ pkt_data;
                        if (!pld_valid) underrun <= 1'b1;
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        tmr_q    <= '0;
                        err_seen <= 1'b0;
                    end
                end
                ERRWIN: begin
                    if (err && !err_seen) begin
                        err_seen <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                    tmr_q <= (tmr_q == WIN_LAST) ? 4'd0 : tmr_q + 4'd1;
                end
                GAP: begin
                    tmr_q <= tmr_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: cycle-by-cycle vector bench for router_pkt_tx.
// Each row drives one cycle of inputs and checks that cycle's outputs.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       start_ready;
    logic       req_reject;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_ready;
    logic       busy;
    logic       err;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_done;
    logic       underrun;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(2), .ERR_WIN(4)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dest_addr(dest_addr), .pay_len(pay_len),
        .start_ready(start_ready), .req_reject(req_reject),
        .pld_data(pld_data), .pld_valid(pld_valid),
        .pld_ready(pld_ready), .busy(busy), .err(err),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_done(pkt_done), .underrun(underrun), .err_cnt(err_cnt)
    );

    typedef struct {
        logic       rst, st;
        logic [1:0] d;
        logic [5:0] l;
        logic [7:0] pd;
        logic       pv, bz, er;
        logic       ev;
        logic [7:0] ed;
        logic       dn, rdy, prd, rej, und;
        logic [7:0] cnt;
    } vec_t;

    vec_t q[$];

    function automatic vec_t v(
        input logic rst, input logic st, input logic [1:0] d,
        input logic [5:0] l, input logic [7:0] pd, input logic pv,
        input logic bz, input logic er, input logic ev,
        input logic [7:0] ed, input logic dn, input logic rdy,
        input logic prd, input logic rej, input logic und,
        input logic [7:0] cnt);
        vec_t r;
        r.rst = rst; r.st = st; r.d = d; r.l = l;
        r.pd = pd; r.pv = pv; r.bz = bz; r.er = er;
        r.ev = ev; r.ed = ed; r.dn = dn; r.rdy = rdy;
        r.prd = prd; r.rej = rej; r.und = und; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic idle_rows(input int n, input logic er,
                             input logic und, input logic [7:0] cnt);
        for (int i = 0; i < n; i++)
            q.push_back(v(0,0,0,0, 8'h00,0,0,er, 0,8'h00,0,0,0,0,und,cnt));
    endtask

    initial begin
        // basic packet: dest 1, len 3, A5 3C 0F -> parity 0D^A5^3C^0F = 9B
        q.push_back(v(0,1,1,3, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h0D,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'hA5,1,0,0, 1,8'hA5,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h3C,1,0,0, 1,8'h3C,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h0F,1,0,0, 1,8'h0F,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h9B,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,1,0,0,0,0,0));
        idle_rows(5, 0, 0, 0);
        // invalid requests
        q.push_back(v(0,1,3,5, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,0));
        q.push_back(v(0,1,0,0, 8'h00,0,0,0, 0,8'h00,0,1,0,1,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,0,1,0,1,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,0));
        // starvation: dest 2, len 2, second byte missing -> 0A^11^00 = 1B
        q.push_back(v(0,1,2,2, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h0A,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h11,1,0,0, 1,8'h11,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h00,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h1B,0,0,0,0,1,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,1,0,0,0,1,0));
        idle_rows(5, 0, 1, 0);
        // next start clears underrun; err one cycle after parity
        q.push_back(v(0,1,0,1, 8'h00,0,0,0, 0,8'h00,0,1,0,0,1,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h04,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h80,1,0,0, 1,8'h80,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h84,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,1, 0,8'h00,1,0,0,0,0,0));
        idle_rows(5, 0, 0, 1);
        // err held everywhere: only the window counts, once
        q.push_back(v(0,1,1,1, 8'h00,0,0,1, 0,8'h00,0,1,0,0,0,1));
        q.push_back(v(0,0,0,0, 8'h00,0,0,1, 1,8'h05,0,0,0,0,0,1));
        q.push_back(v(0,0,0,0, 8'hFF,1,0,1, 1,8'hFF,0,0,1,0,0,1));
        q.push_back(v(0,0,0,0, 8'h00,0,0,1, 0,8'hFA,0,0,0,0,0,1));
        q.push_back(v(0,0,0,0, 8'h00,0,0,1, 0,8'h00,1,0,0,0,0,1));
        idle_rows(5, 1, 0, 2);
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,2));
        // busy stall on first payload byte and on parity -> 0A^12^34 = 2C
        q.push_back(v(0,1,2,2, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h0A,0,0,0,0,0,2));
        for (int i = 0; i < 3; i++)
            q.push_back(v(0,0,0,0, 8'h12,1,1,0, 1,8'h12,0,0,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'h12,1,0,0, 1,8'h12,0,0,1,0,0,2));
        q.push_back(v(0,0,0,0, 8'h34,1,0,0, 1,8'h34,0,0,1,0,0,2));
        q.push_back(v(0,0,0,0, 8'h00,0,1,0, 0,8'h2C,0,0,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h2C,0,0,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,1,0,0,0,0,2));
        idle_rows(5, 0, 0, 2);
        // reset during second payload byte, then a clean packet
        q.push_back(v(0,1,1,3, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h0D,0,0,0,0,0,2));
        q.push_back(v(0,0,0,0, 8'hA5,1,0,0, 1,8'hA5,0,0,1,0,0,2));
        q.push_back(v(1,0,0,0, 8'h3C,1,0,0, 1,8'h3C,0,0,1,0,0,2));
        q.push_back(v(0,1,0,1, 8'h00,0,0,0, 0,8'h00,0,1,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 1,8'h04,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h55,1,0,0, 1,8'h55,0,0,1,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h51,0,0,0,0,0,0));
        q.push_back(v(0,0,0,0, 8'h00,0,0,0, 0,8'h00,1,0,0,0,0,0));

        reset = 1'b1; start = 1'b0; dest_addr = '0; pay_len = '0;
        pld_data = '0; pld_valid = 1'b0; busy = 1'b0; err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < q.size(); i++) begin
            reset = q[i].rst; start = q[i].st;
            dest_addr = q[i].d; pay_len = q[i].l;
            pld_data = q[i].pd; pld_valid = q[i].pv;
            busy = q[i].bz; err = q[i].er;
            #1;
            chk("pkt_valid",   i, {7'd0, pkt_valid},   {7'd0, q[i].ev});
            chk("pkt_data",    i, pkt_data,            q[i].ed);
            chk("pkt_done",    i, {7'd0, pkt_done},    {7'd0, q[i].dn});
            chk("start_ready", i, {7'd0, start_ready}, {7'd0, q[i].rdy});
            chk("pld_ready",   i, {7'd0, pld_ready},   {7'd0, q[i].prd});
            chk("req_reject",  i, {7'd0, req_reject},  {7'd0, q[i].rej});
            chk("underrun",    i, {7'd0, underrun},    {7'd0, q[i].und});
            chk("err_cnt",     i, err_cnt,             q[i].cnt);
            @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
